key_cmd_arbiter: RTL



---
 rtl/key_cmd_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/key_cmd_arbiter.sv
// key_cmd_arbiter: collects debounced key pulses, adds auto-repeat for held
// keys, keeps one pending event per key and hands them to the game engine
// one at a time over valid/ready, using round-robin to prevent starvation.
module key_cmd_arbiter #(
    parameter int unsigned          NUM_KEYS     = 5,
    parameter int unsigned          ID_W         = 3,
    parameter int unsigned          CNT_W        = 24,
    parameter int unsigned          REPEAT_DELAY = 12_500_000,
    parameter int unsigned          REPEAT_RATE  = 2_500_000,
    parameter logic [NUM_KEYS-1:0]  REPEAT_MASK  = 5'b00111
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_pulse,
    input  logic [NUM_KEYS-1:0] key_held,
    input  logic                flush,
    input  logic                cmd_ready,
    output logic                cmd_valid,
    output logic [ID_W-1:0]     cmd_id,
    output logic                overflow
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } rep_state_t;

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    rep_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]     rep_key_q, rep_key_d;
    logic [NUM_KEYS-1:0] pending_q, pending_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [ID_W-1:0]     cmd_id_q, cmd_id_d;
    logic                overflow_q, overflow_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic [NUM_KEYS-1:0] mpulse;
    logic                m_found;
    logic [ID_W-1:0]     m_key;
    logic [NUM_KEYS-1:0] rep_onehot;
    logic                held_rep;
    logic [CNT_W-1:0]    cnt_limit;
    logic                repeat_tick;

    logic [NUM_KEYS-1:0] rot;
    logic                found;
    logic [ID_W-1:0]     pick;
    int unsigned         sum;
    logic                load_en;
    logic [NUM_KEYS-1:0] set_vec;
    logic [NUM_KEYS-1:0] load_vec;

    // Auto-repeat FSM: next state, counter and repeat tick for the latest masked key
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rep_key_d   = rep_key_q;
        repeat_tick = 1'b0;
        mpulse      = key_pulse & REPEAT_MASK;
        m_found     = 1'b0;
        m_key       = '0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if (!m_found && ((mpulse >> k) & NUM_KEYS'(1)) != '0) begin
                m_found = 1'b1;
                m_key   = ID_W'(k);
            end
        end
        rep_onehot = NUM_KEYS'(1) << rep_key_q;
        held_rep   = |(key_held & rep_onehot);
        cnt_limit  = (state_q == ST_DELAY) ? DELAY_LAST : RATE_LAST;

        case (state_q)
            ST_IDLE: begin
                if (m_found) begin
                    rep_key_d = m_key;
                    cnt_d     = '0;
                    state_d   = ST_DELAY;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                // A fresh masked press outranks both release and tick
                if (m_found) begin
                    rep_key_d = m_key;
                    cnt_d     = '0;
                    state_d   = ST_DELAY;
                end else if (!held_rep) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == cnt_limit) begin
                    repeat_tick = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_REPEAT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            repeat_tick = 1'b0;
            cnt_d       = '0;
            state_d     = ST_IDLE;
        end
    end

    // Pending set/clear, round-robin pick and output register next values
    always_comb begin
        load_en = !cmd_valid_q || cmd_ready;
        // Rotate pending so bit 0 corresponds to rr_ptr, then take the lowest set bit
        rot   = NUM_KEYS'({pending_q, pending_q} >> rr_ptr_q);
        found = 1'b0;
        pick  = '0;
        sum   = 0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if (!found && ((rot >> k) & NUM_KEYS'(1)) != '0) begin
                found = 1'b1;
                sum   = 32'(rr_ptr_q) + k;
                if (sum >= NUM_KEYS) begin
                    sum = sum - NUM_KEYS;
                end
                pick = ID_W'(sum);
            end
        end

        set_vec  = key_pulse | (repeat_tick ? (NUM_KEYS'(1) << rep_key_q) : '0);
        load_vec = (load_en && found) ? (NUM_KEYS'(1) << pick) : '0;

        pending_d   = (pending_q & ~load_vec) | set_vec;
        overflow_d  = |(set_vec & pending_q & ~load_vec);
        cmd_valid_d = cmd_valid_q;
        cmd_id_d    = cmd_id_q;
        rr_ptr_d    = rr_ptr_q;

        if (load_en) begin
            if (found) begin
                cmd_valid_d = 1'b1;
                cmd_id_d    = pick;
                rr_ptr_d    = (pick == ID_W'(NUM_KEYS - 1)) ? '0 : pick + ID_W'(1);
            end else begin
                cmd_valid_d = 1'b0;
            end
        end

        if (flush) begin
            pending_d   = '0;
            overflow_d  = 1'b0;
            cmd_valid_d = 1'b0;
            cmd_id_d    = cmd_id_q;
            rr_ptr_d    = rr_ptr_q;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rep_key_q   <= '0;
            pending_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_id_q    <= '0;
            overflow_q  <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rep_key_q   <= rep_key_d;
            pending_q   <= pending_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_id_q    <= cmd_id_d;
            overflow_q  <= overflow_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_id    = cmd_id_q;
    assign overflow  = overflow_q;

endmodule
